mempool_tcdm_channel_mux: RTL and testbench

// Parametrised remote-port concentrator between the cores of one tile and NumChannels

---
 rtl/mempool_tcdm_channel_mux.sv | 220 ++++++++++++++++++++++
 tb/tb_mempool_tcdm_channel_mux.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mempool_tcdm_channel_mux.sv
`default_nettype none
// ============================================================================
// Module      : mempool_tcdm_channel_mux
// Description : Concentrates a tile's core requests onto address-selected
//               remote channels and routes tagged responses back to cores.
// Revision    : 1.0
// ============================================================================
module mempool_tcdm_channel_mux #(
    parameter int NUM_IN          = 4,
    parameter int NUM_CHANNELS    = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int CHAN_SEL_OFFSET = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_WIDTH       = DATA_WIDTH / 8,
    localparam int INI_WIDTH      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_IN-1:0]                  in_req_valid_i,
    output logic [NUM_IN-1:0]                  in_req_ready_o,
    input  logic [NUM_IN*ADDR_WIDTH-1:0]       in_req_addr_i,
    input  logic [NUM_IN-1:0]                  in_req_wen_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0]       in_req_wdata_i,
    input  logic [NUM_IN*BE_WIDTH-1:0]         in_req_be_i,
    output logic [NUM_IN-1:0]                  in_resp_valid_o,
    input  logic [NUM_IN-1:0]                  in_resp_ready_i,
    output logic [NUM_IN*DATA_WIDTH-1:0]       in_resp_rdata_o,
    output logic [NUM_CHANNELS-1:0]            out_req_valid_o,
    input  logic [NUM_CHANNELS-1:0]            out_req_ready_i,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] out_req_addr_o,
    output logic [NUM_CHANNELS-1:0]            out_req_wen_o,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_req_wdata_o,
    output logic [NUM_CHANNELS*BE_WIDTH-1:0]   out_req_be_o,
    output logic [NUM_CHANNELS*INI_WIDTH-1:0]  out_req_ini_o,
    input  logic [NUM_CHANNELS-1:0]            out_resp_valid_i,
    output logic [NUM_CHANNELS-1:0]            out_resp_ready_o,
    input  logic [NUM_CHANNELS*INI_WIDTH-1:0]  out_resp_ini_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_resp_rdata_i
);

    localparam int c_SEL_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_WIDTH-1:0] c_MAX_CNT = c_CNT_WIDTH'(MAX_OUTSTANDING);

    // Cyclic index (base + ofs) mod n, valid for base, ofs < n.
    function automatic int wrap_add(input int base, input int ofs, input int n);
        int s;
        s = base + ofs;
        if (s >= n) s = s - n;
        return s;
    endfunction

    logic [ADDR_WIDTH-1:0]  w_in_addr  [NUM_IN];
    logic [DATA_WIDTH-1:0]  w_in_wdata [NUM_IN];
    logic [BE_WIDTH-1:0]    w_in_be    [NUM_IN];
    logic [c_SEL_BITS-1:0]  w_in_chan  [NUM_IN];
    logic [NUM_IN-1:0]      w_in_avail;
    logic [c_CNT_WIDTH-1:0] r_cnt      [NUM_IN];
    logic [NUM_IN-1:0]      w_req_hs;
    logic [NUM_IN-1:0]      w_resp_hs;

    logic [NUM_CHANNELS-1:0] w_load;
    logic [INI_WIDTH-1:0]    w_gnt_idx [NUM_CHANNELS];

    logic [NUM_IN-1:0]      w_sel_valid;
    logic [c_SEL_BITS-1:0]  w_sel_idx [NUM_IN];

    // ------------------------------------------------------------------
    // Per-core request unpacking and credit check
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign w_in_addr[i]  = in_req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_in_wdata[i] = in_req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in_be[i]    = in_req_be_i[i*BE_WIDTH +: BE_WIDTH];
        if (NUM_CHANNELS > 1) begin : g_sel
            assign w_in_chan[i] = w_in_addr[i][CHAN_SEL_OFFSET +: c_SEL_BITS];
        end else begin : g_nosel
            assign w_in_chan[i] = '0;
        end
        assign w_in_avail[i] = in_req_valid_i[i] && (r_cnt[i] < c_MAX_CNT);
    end

    // ------------------------------------------------------------------
    // Per-channel round-robin arbiter and one-entry output register
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [NUM_IN-1:0]     w_elig;
        logic                  w_gnt_valid;
        logic [INI_WIDTH-1:0]  w_gnt;
        logic                  r_valid;
        logic                  r_wen;
        logic [ADDR_WIDTH-1:0] r_addr;
        logic [DATA_WIDTH-1:0] r_wdata;
        logic [BE_WIDTH-1:0]   r_be;
        logic [INI_WIDTH-1:0]  r_ini;
        logic [INI_WIDTH-1:0]  r_rr_ptr;

        // Scan from lowest to highest priority so the last hit wins.
        always_comb begin
            w_elig      = '0;
            w_gnt_valid = 1'b0;
            w_gnt       = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                w_elig[i] = w_in_avail[i] && (w_in_chan[i] == c_SEL_BITS'(c));
            end
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (w_elig[wrap_add(int'(r_rr_ptr), k, NUM_IN)]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt       = INI_WIDTH'(wrap_add(int'(r_rr_ptr), k, NUM_IN));
                end
            end
        end

        assign w_load[c]    = w_gnt_valid && (!r_valid || out_req_ready_i[c]);
        assign w_gnt_idx[c] = w_gnt;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_valid  <= 1'b0;
                r_wen    <= 1'b0;
                r_addr   <= '0;
                r_wdata  <= '0;
                r_be     <= '0;
                r_ini    <= '0;
                r_rr_ptr <= '0;
            end else if (w_load[c]) begin
                r_valid  <= 1'b1;
                r_wen    <= in_req_wen_i[w_gnt];
                r_addr   <= w_in_addr[w_gnt];
                r_wdata  <= w_in_wdata[w_gnt];
                r_be     <= w_in_be[w_gnt];
                r_ini    <= w_gnt;
                r_rr_ptr <= INI_WIDTH'(wrap_add(int'(w_gnt), 1, NUM_IN));
            end else if (out_req_ready_i[c]) begin
                r_valid  <= 1'b0;
            end
        end

        assign out_req_valid_o[c]                           = r_valid;
        assign out_req_wen_o[c]                             = r_wen;
        assign out_req_addr_o[c*ADDR_WIDTH +: ADDR_WIDTH]   = r_addr;
        assign out_req_wdata_o[c*DATA_WIDTH +: DATA_WIDTH]  = r_wdata;
        assign out_req_be_o[c*BE_WIDTH +: BE_WIDTH]         = r_be;
        assign out_req_ini_o[c*INI_WIDTH +: INI_WIDTH]      = r_ini;
    end

    always_comb begin
        in_req_ready_o = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_load[c]) in_req_ready_o[w_gnt_idx[c]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-core response selection and outstanding-request credits
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_IN; i++) begin : g_resp
        logic [NUM_CHANNELS-1:0] w_tgt;
        logic                    w_found;
        logic [c_SEL_BITS-1:0]   w_pick;
        logic [c_SEL_BITS-1:0]   r_resp_ptr;
        logic [DATA_WIDTH-1:0]   w_rdata;

        always_comb begin
            w_tgt   = '0;
            w_found = 1'b0;
            w_pick  = '0;
            w_rdata = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                w_tgt[c] = out_resp_valid_i[c] &&
                           (out_resp_ini_i[c*INI_WIDTH +: INI_WIDTH] == INI_WIDTH'(i));
            end
            for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
                if (w_tgt[wrap_add(int'(r_resp_ptr), k, NUM_CHANNELS)]) begin
                    w_found = 1'b1;
                    w_pick  = c_SEL_BITS'(wrap_add(int'(r_resp_ptr), k, NUM_CHANNELS));
                end
            end
            if (w_found) w_rdata = out_resp_rdata_i[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
        end

        assign w_sel_valid[i] = w_found && !rst_i;
        assign w_sel_idx[i]   = w_pick;
        assign in_resp_valid_o[i]                          = w_sel_valid[i];
        assign in_resp_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = w_rdata;

        assign w_req_hs[i]  = in_req_valid_i[i] && in_req_ready_o[i];
        assign w_resp_hs[i] = in_resp_valid_o[i] && in_resp_ready_i[i];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_resp_ptr <= '0;
                r_cnt[i]   <= '0;
            end else begin
                if (w_resp_hs[i]) begin
                    r_resp_ptr <= c_SEL_BITS'(wrap_add(int'(w_pick), 1, NUM_CHANNELS));
                end
                if (w_req_hs[i] && !w_resp_hs[i] && (r_cnt[i] != c_MAX_CNT)) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_WIDTH'(1);
                end else if (!w_req_hs[i] && w_resp_hs[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - c_CNT_WIDTH'(1);
                end
            end
        end

        // A response for a core with nothing outstanding is unsolicited.
        a_no_unsolicited_resp: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_resp_hs[i] && (r_cnt[i] == '0)));
    end

    always_comb begin
        out_resp_ready_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_sel_valid[i] && in_resp_ready_i[i]) out_resp_ready_o[w_sel_idx[i]] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mempool_tcdm_channel_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_mempool_tcdm_channel_mux
// Description : Directed self-checking bench for mempool_tcdm_channel_mux.
// Revision    : 1.0
// ============================================================================
module tb_mempool_tcdm_channel_mux;

    localparam int NI = 4;
    localparam int NC = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;

    logic [NI-1:0]    in_req_valid, in_req_ready, in_req_wen;
    logic [NI*AW-1:0] in_req_addr;
    logic [NI*DW-1:0] in_req_wdata;
    logic [NI*BW-1:0] in_req_be;
    logic [NI-1:0]    in_resp_valid, in_resp_ready;
    logic [NI*DW-1:0] in_resp_rdata;
    logic [NC-1:0]    out_req_valid, out_req_ready, out_req_wen;
    logic [NC*AW-1:0] out_req_addr;
    logic [NC*DW-1:0] out_req_wdata;
    logic [NC*BW-1:0] out_req_be;
    logic [NC*IW-1:0] out_req_ini;
    logic [NC-1:0]    out_resp_valid, out_resp_ready;
    logic [NC*IW-1:0] out_resp_ini;
    logic [NC*DW-1:0] out_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mempool_tcdm_channel_mux #(
        .NUM_IN(NI), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CHAN_SEL_OFFSET(2), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready),
        .in_req_addr_i(in_req_addr), .in_req_wen_i(in_req_wen),
        .in_req_wdata_i(in_req_wdata), .in_req_be_i(in_req_be),
        .in_resp_valid_o(in_resp_valid), .in_resp_ready_i(in_resp_ready),
        .in_resp_rdata_o(in_resp_rdata),
        .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready),
        .out_req_addr_o(out_req_addr), .out_req_wen_o(out_req_wen),
        .out_req_wdata_o(out_req_wdata), .out_req_be_o(out_req_be),
        .out_req_ini_o(out_req_ini),
        .out_resp_valid_i(out_resp_valid), .out_resp_ready_o(out_resp_ready),
        .out_resp_ini_i(out_resp_ini), .out_resp_rdata_i(out_resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_req_valid   = '0;
        in_req_wen     = '0;
        in_req_addr    = '0;
        in_req_wdata   = '0;
        in_req_be      = '0;
        in_resp_ready  = '0;
        out_req_ready  = '1;
        out_resp_valid = '0;
        out_resp_ini   = '0;
        out_resp_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] be);
        in_req_valid[i]          = 1'b1;
        in_req_wen[i]            = wen;
        in_req_addr[i*AW +: AW]  = addr;
        in_req_wdata[i*DW +: DW] = wdata;
        in_req_be[i*BW +: BW]    = be;
    endtask

    function automatic logic [31:0] ch_addr(input int c);
        return out_req_addr[c*AW +: AW];
    endfunction
    function automatic logic [31:0] ch_wdata(input int c);
        return out_req_wdata[c*DW +: DW];
    endfunction
    function automatic logic [3:0] ch_be(input int c);
        return out_req_be[c*BW +: BW];
    endfunction
    function automatic logic [1:0] ch_ini(input int c);
        return out_req_ini[c*IW +: IW];
    endfunction
    function automatic logic [31:0] core_rdata(input int i);
        return in_resp_rdata[i*DW +: DW];
    endfunction

    logic [31:0] a_dat [2];
    logic [31:0] b_dat [2];
    int ia, ib, win;

    initial begin
        rst = 1'b1;
        idle();

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            in_req_valid   = NI'($urandom);
            in_req_wen     = NI'($urandom);
            in_req_addr    = {$urandom, $urandom, $urandom, $urandom};
            in_req_wdata   = {$urandom, $urandom, $urandom, $urandom};
            in_req_be      = 16'($urandom);
            in_resp_ready  = NI'($urandom);
            out_req_ready  = NC'($urandom);
            out_resp_valid = NC'($urandom);
            out_resp_ini   = 4'($urandom);
            out_resp_rdata = {$urandom, $urandom};
            tick();
            check("rst_out_req_valid", 64'(out_req_valid), 64'h0);
            check("rst_in_resp_valid", 64'(in_resp_valid), 64'h0);
        end
        idle();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_out_req_valid", 64'(out_req_valid), 64'h0);
        check("post_rst_in_resp_valid", 64'(in_resp_valid), 64'h0);

        // Single request, core 2 to channel 1
        do_reset();
        set_req(2, 32'h104, 1'b1, 32'hDEAD_BEEF, 4'hA);
        #1;
        check("single_in_ready", 64'(in_req_ready), 64'h4);
        tick();
        in_req_valid = '0;
        #1;
        check("single_out_valid", 64'(out_req_valid), 64'h2);
        check("single_addr", 64'(ch_addr(1)), 64'h104);
        check("single_ini", 64'(ch_ini(1)), 64'h2);
        check("single_wdata", 64'(ch_wdata(1)), 64'hDEAD_BEEF);
        check("single_be", 64'(ch_be(1)), 64'hA);
        check("single_wen", 64'(out_req_wen[1]), 64'h1);
        tick();
        check("single_drained", 64'(out_req_valid), 64'h0);

        // Fairness: all cores to channel 0
        do_reset();
        for (int i = 0; i < NI; i++) set_req(i, 32'h1000 + 32'(i * 16), 1'b0, 32'(i), 4'h1);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_in_ready", 64'(in_req_ready), 64'h1 << (k % 4));
            tick();
            check("rr_out_valid", 64'(out_req_valid), 64'h1);
            check("rr_ini", 64'(ch_ini(0)), 64'(k % 4));
            check("rr_addr", 64'(ch_addr(0)), 64'h1000 + 64'((k % 4) * 16));
        end

        // Backpressure on channel 0
        do_reset();
        set_req(0, 32'h2000, 1'b0, 32'h1111_0000, 4'hF);
        set_req(1, 32'h2010, 1'b1, 32'h2222_0000, 4'h3);
        #1;
        check("bp_first_ready", 64'(in_req_ready), 64'h1);
        tick();
        out_req_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", 64'(in_req_ready), 64'h0);
            check("bp_out_valid", 64'(out_req_valid[0]), 64'h1);
            check("bp_addr", 64'(ch_addr(0)), 64'h2000);
            check("bp_wdata", 64'(ch_wdata(0)), 64'h1111_0000);
            tick();
        end
        out_req_ready[0] = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_req_ready), 64'h2);
        tick();
        in_req_valid = '0;
        check("bp_next_ini", 64'(ch_ini(0)), 64'h1);
        check("bp_next_addr", 64'(ch_addr(0)), 64'h2010);

        // Credits for core 1 on channel 1
        do_reset();
        set_req(1, 32'h4, 1'b0, 32'h5555_5555, 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cr_ready", 64'(in_req_ready), 64'h2);
            tick();
        end
        #1;
        check("cr_stall", 64'(in_req_ready), 64'h0);
        tick();
        out_resp_valid = 2'b10;
        out_resp_ini   = {2'd1, 2'd0};
        out_resp_rdata = {32'h0000_CAFE, 32'h0};
        in_resp_ready  = 4'b0010;
        #1;
        check("cr_resp_stall", 64'(in_req_ready), 64'h0);
        check("cr_resp_valid", 64'(in_resp_valid), 64'h2);
        check("cr_resp_rdata", 64'(core_rdata(1)), 64'h0000_CAFE);
        check("cr_resp_chready", 64'(out_resp_ready), 64'h2);
        tick();
        out_resp_rdata = {32'h0000_CAFF, 32'h0};
        #1;
        check("cr_fifth", 64'(in_req_ready), 64'h2);
        check("cr_fifth_chready", 64'(out_resp_ready), 64'h2);
        tick();
        out_resp_valid = '0;
        #1;
        check("cr_sixth", 64'(in_req_ready), 64'h2);
        tick();
        check("cr_seventh_stall", 64'(in_req_ready), 64'h0);

        // Response collision on core 3
        do_reset();
        set_req(3, 32'h3000, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("col_req_ready", 64'(in_req_ready), 64'h8);
            tick();
        end
        in_req_valid = '0;
        a_dat[0] = 32'hAAAA_0000;
        a_dat[1] = 32'hAAAA_0001;
        b_dat[0] = 32'hBBBB_0000;
        b_dat[1] = 32'hBBBB_0001;
        ia = 0;
        ib = 0;
        out_resp_ini  = {2'd3, 2'd3};
        in_resp_ready = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            out_resp_valid = {ib < 2, ia < 2};
            out_resp_rdata = {(ib < 2) ? b_dat[ib] : 32'h0, (ia < 2) ? a_dat[ia] : 32'h0};
            #1;
            win = k % 2;
            check("col_valid", 64'(in_resp_valid), 64'h8);
            check("col_rdata", 64'(core_rdata(3)), 64'((win == 0) ? a_dat[k / 2] : b_dat[k / 2]));
            check("col_chready", 64'(out_resp_ready), 64'h1 << win);
            tick();
            if (win == 0) ia++;
            else ib++;
        end
        out_resp_valid = '0;
        #1;
        check("col_idle", 64'(in_resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
